// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : LEGv8 exception/interrupt controller with masked, pending IRQ
//            channels, ELR capture, one-cycle redirect and double-fault halt.
//            Optional EXC_CNT_EN adds a saturating exception counter (ExcCnt).
// Revision : 1.0
// ============================================================================
module exc_ctrl #(
  parameter int              N_IRQ = 4,
  parameter int              PC_W  = 64,
  parameter logic [PC_W-1:0] EVEC  = PC_W'(64'h00000000000000D8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] IRQ,
  input  logic [N_IRQ-1:0] IrqMask,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic [PC_W-1:0]  PC_in,
  output logic             Exc,
  output logic [PC_W-1:0]  ExcVector,
  output logic [PC_W-1:0]  ELR,
  output logic [3:0]       EStatus,
  output logic             InHandler,
  output logic             Halt,
  output logic [N_IRQ-1:0] Pending
`ifdef EXC_CNT_EN
  ,
  output logic [15:0]      ExcCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    DEAD    = 2'd3
  } state_t;

  localparam logic [3:0] ST_NONE    = 4'b0000;
  localparam logic [3:0] ST_INVALID = 4'b0010;
  localparam logic [3:0] ST_DOUBLE  = 4'b1111;

  state_t            state, state_next;
  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  pending;
  logic [N_IRQ-1:0]  rise;
  logic [N_IRQ-1:0]  eligible;
  logic [N_IRQ-1:0]  clr;
  logic [2:0]        grant_idx;
  logic              grant_vld;
  logic              take_irq;
  logic              enter_take;
  logic [3:0]        estatus, estatus_next;
  logic [PC_W-1:0]   elr, elr_next;

  assign rise     = IRQ & ~irq_q;
  assign eligible = pending & ~IrqMask;

  // Lowest index wins: scan high-to-low so the last hit is the smallest.
  always_comb begin
    grant_idx = 3'd0;
    grant_vld = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_idx = 3'(i);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = take_irq && (grant_idx == 3'(i));
    end
  end

  always_comb begin
    state_next   = state;
    estatus_next = estatus;
    elr_next     = elr;
    take_irq     = 1'b0;
    enter_take   = 1'b0;
    case (state)
      IDLE: begin
        if (NotAnInstr) begin
          state_next   = TAKE;
          estatus_next = ST_INVALID;
          elr_next     = PC_in;
          enter_take   = 1'b1;
        end else if (grant_vld) begin
          state_next   = TAKE;
          estatus_next = {1'b1, grant_idx};
          elr_next     = PC_in;
          take_irq     = 1'b1;
          enter_take   = 1'b1;
        end
      end
      TAKE: state_next = HANDLER;
      HANDLER: begin
        if (ERet) begin
          state_next   = IDLE;
          estatus_next = ST_NONE;
        end else if (NotAnInstr) begin
          state_next   = DEAD;
          estatus_next = ST_DOUBLE;
        end
      end
      DEAD: state_next = DEAD;
      default: state_next = IDLE;
    endcase
  end

  // A fresh edge on the channel being cleared stays pending (set wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      irq_q   <= '0;
      pending <= '0;
      estatus <= ST_NONE;
      elr     <= '0;
    end else begin
      state   <= state_next;
      irq_q   <= IRQ;
      pending <= (pending & ~clr) | rise;
      estatus <= estatus_next;
      elr     <= elr_next;
    end
  end

  assign Exc       = (state == TAKE);
  assign InHandler = (state == TAKE) || (state == HANDLER);
  assign Halt      = (state == DEAD);
  assign ExcVector = EVEC;
  assign ELR       = elr;
  assign EStatus   = estatus;
  assign Pending   = pending;

`ifdef EXC_CNT_EN
  logic [15:0] exc_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt <= '0;
    end else if (enter_take && (exc_cnt != 16'hFFFF)) begin
      exc_cnt <= exc_cnt + 16'd1;
    end
  end

  assign ExcCnt = exc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Directed and randomized bench for exc_ctrl against a reference model.
// Revision : 1.0
// ============================================================================
module tb_exc_ctrl;
  localparam int N_IRQ = 4;
  localparam int PC_W  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_IRQ-1:0] IRQ;
  logic [N_IRQ-1:0] IrqMask;
  logic             NotAnInstr;
  logic             ERet;
  logic [PC_W-1:0]  PC_in;
  logic             Exc;
  logic [PC_W-1:0]  ExcVector;
  logic [PC_W-1:0]  ELR;
  logic [3:0]       EStatus;
  logic             InHandler;
  logic             Halt;
  logic [N_IRQ-1:0] Pending;
`ifdef EXC_CNT_EN
  logic [15:0]      ExcCnt;
`endif

  exc_ctrl #(.N_IRQ(N_IRQ), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .IRQ(IRQ), .IrqMask(IrqMask),
    .NotAnInstr(NotAnInstr), .ERet(ERet), .PC_in(PC_in),
    .Exc(Exc), .ExcVector(ExcVector), .ELR(ELR), .EStatus(EStatus),
    .InHandler(InHandler), .Halt(Halt), .Pending(Pending)
`ifdef EXC_CNT_EN
    , .ExcCnt(ExcCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no exception, 1 = redirect cycle,
  // 2 = handler running, 3 = halted on double fault.
  int              m_phase;
  bit [N_IRQ-1:0]  m_pend;
  bit [N_IRQ-1:0]  m_prev;
  bit [63:0]       m_elr;
  int              m_cause;
  int              m_cnt;

  task automatic model_edge();
    bit [N_IRQ-1:0] r;
    int taken;
    if (reset) begin
      m_phase = 0; m_pend = '0; m_prev = '0; m_elr = 0; m_cause = 0; m_cnt = 0;
      return;
    end
    r      = IRQ & ~m_prev;
    m_prev = IRQ;
    taken  = -1;
    if (m_phase == 0) begin
      if (NotAnInstr) begin
        m_phase = 1; m_cause = 2; m_elr = PC_in;
      end else begin
        for (int i = 0; i < N_IRQ; i++)
          if (taken < 0 && m_pend[i] && !IrqMask[i]) taken = i;
        if (taken >= 0) begin
          m_phase = 1; m_cause = 8 + taken; m_elr = PC_in;
        end
      end
      if (m_phase == 1 && m_cnt < 65535) m_cnt++;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (ERet) begin
        m_phase = 0; m_cause = 0;
      end else if (NotAnInstr) begin
        m_phase = 3; m_cause = 15;
      end
    end
    if (taken >= 0) m_pend[taken] = 1'b0;
    m_pend = m_pend | r;
  endtask

  task automatic compare_all();
    check("exc",       64'(Exc),       64'(m_phase == 1));
    check("inhandler", 64'(InHandler), 64'(m_phase == 1 || m_phase == 2));
    check("halt",      64'(Halt),      64'(m_phase == 3));
    check("elr",       ELR,            m_elr);
    check("estatus",   64'(EStatus),   64'(m_cause));
    check("pending",   64'(Pending),   64'(m_pend));
    check("vector",    ExcVector,      64'hD8);
`ifdef EXC_CNT_EN
    check("exccnt",    64'(ExcCnt),    64'(m_cnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; IRQ = '0; IrqMask = '0; NotAnInstr = 1'b0; ERet = 1'b0; PC_in = '0;
    step(); step();
    check("rst_exc", 64'(Exc), 64'd0);
    check("rst_estatus", 64'(EStatus), 64'd0);
    reset = 1'b0;
    step();

    // Invalid instruction
    NotAnInstr = 1'b1; PC_in = 64'h40;
    step();
    check("inv_exc", 64'(Exc), 64'd1);
    check("inv_elr", ELR, 64'h40);
    check("inv_estatus", 64'(EStatus), 64'b0010);
    NotAnInstr = 1'b0;
    step();
    check("inv_exc_once", 64'(Exc), 64'd0);
    ERet = 1'b1;
    step();
    check("inv_eret_st", 64'(EStatus), 64'd0);
    check("inv_eret_ih", 64'(InHandler), 64'd0);
    ERet = 1'b0;

    // Simultaneous IRQ1 and IRQ3
    IRQ = 4'b1010; PC_in = 64'h100;
    step(); step();
    check("irq13_exc", 64'(Exc), 64'd1);
    check("irq13_st", 64'(EStatus), 64'b1001);
    check("irq13_pend", 64'(Pending), 64'b1000);
    step();
    ERet = 1'b1; step();
    ERet = 1'b0; step();
    check("irq3_exc", 64'(Exc), 64'd1);
    check("irq3_st", 64'(EStatus), 64'b1011);
    check("irq3_pend", 64'(Pending), 64'b0000);
    IRQ = '0;
    step(); ERet = 1'b1; step(); ERet = 1'b0;

    // Masked channel stays pending until unmasked
    IrqMask = 4'b0100; IRQ = 4'b0100;
    step();
    check("mask_pend", 64'(Pending), 64'b0100);
    for (int i = 0; i < 10; i++) begin
      step();
      check("mask_noexc", 64'(Exc), 64'd0);
    end
    IrqMask = '0;
    step();
    check("unmask_exc", 64'(Exc), 64'd1);
    check("unmask_st", 64'(EStatus), 64'b1010);
    IRQ = '0;
    step(); ERet = 1'b1; step(); ERet = 1'b0;

    // Sync fault beats a pending IRQ0
    IrqMask = 4'b0001; IRQ = 4'b0001;
    step();
    IrqMask = '0; NotAnInstr = 1'b1;
    step();
    check("prio_st", 64'(EStatus), 64'b0010);
    check("prio_pend", 64'(Pending[0]), 64'd1);
    NotAnInstr = 1'b0; IRQ = '0;
    step(); ERet = 1'b1; step(); ERet = 1'b0;
    step();
    check("prio_irq0_st", 64'(EStatus), 64'b1000);
    step(); ERet = 1'b1; step(); ERet = 1'b0;

    // Double fault
    NotAnInstr = 1'b1; step();
    NotAnInstr = 1'b0; step();
    NotAnInstr = 1'b1; step();
    check("dead_st", 64'(EStatus), 64'hF);
    check("dead_halt", 64'(Halt), 64'd1);
    NotAnInstr = 1'b0; ERet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IRQ = 4'(i * 5);
      step();
    end
    check("dead_sticky", 64'(Halt), 64'd1);
    check("dead_noexc", 64'(Exc), 64'd0);
    ERet = 1'b0; IRQ = '0; reset = 1'b1;
    step();
    check("dead_rst_halt", 64'(Halt), 64'd0);
    check("dead_rst_st", 64'(EStatus), 64'd0);
    reset = 1'b0;

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      IRQ        = 4'($urandom);
      IrqMask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      NotAnInstr = ($urandom_range(0, 11) == 0);
      ERet       = ($urandom_range(0, 3) == 0);
      PC_in      = {32'($urandom), 32'($urandom)};
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
